// File: rtl/sun2_mem_pkg.sv
// Shared definitions for the 120 CPU board memory path.
// Holds the refresh sequencer state encoding and its default timing constants.
package sun2_mem_pkg;

   localparam int unsigned REF_T_RAS      = 3;
   localparam int unsigned REF_T_RP       = 2;
   localparam int unsigned REF_ROW_BITS   = 8;
   localparam int unsigned REF_PHASE_BITS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      RAS  = 2'd2,
      PRE  = 2'd3
   } ref_state_t;

endpackage

// File: rtl/refresh_row_ctr.sv
// Refresh row address counter: wraps at 2^W, synchronous clear has priority.
// Ports:
//   i_clk    clock
//   i_clr    synchronous clear to zero
//   i_inc    advance by one row
//   o_count  current row (registered)
module refresh_row_ctr #(
   parameter int unsigned W = 8
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_count <= '0;
      end else if (i_inc) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dram_refresh_ctl.sv
// Refresh sequencer and DRAM port arbiter. Takes the timer controller's
// refresh request, runs a RAS-only refresh (RAS then precharge), acknowledges
// with a one-cycle ren_n strobe, and otherwise grants the port to the CPU.
// Ports:
//   CLK        system clock
//   RESET      synchronous active-high reset
//   rreq_n     refresh request from timer controller (active low, level)
//   ren_n      refresh acknowledge strobe (active low, one cycle)
//   cpu_req    CPU memory cycle request
//   cpu_done   CPU memory cycle complete (only looked at while granted)
//   cpu_grant  DRAM port owned by the CPU
//   ref_ras_n  refresh RAS (active low)
//   ref_addr   refresh row address
//   ref_busy   refresh in progress including precharge
module dram_refresh_ctl #(
   parameter int unsigned ROW_BITS = sun2_mem_pkg::REF_ROW_BITS,
   parameter int unsigned T_RAS    = sun2_mem_pkg::REF_T_RAS,
   parameter int unsigned T_RP     = sun2_mem_pkg::REF_T_RP
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                rreq_n,
   output logic                ren_n,
   input  logic                cpu_req,
   input  logic                cpu_done,
   output logic                cpu_grant,
   output logic                ref_ras_n,
   output logic [ROW_BITS-1:0] ref_addr,
   output logic                ref_busy
);

   import sun2_mem_pkg::*;

   // Last phase value of each timed state; phase counts 0..T-1.
   localparam logic [REF_PHASE_BITS-1:0] PH_RAS_LAST = REF_PHASE_BITS'(T_RAS - 1);
   localparam logic [REF_PHASE_BITS-1:0] PH_RP_LAST  = REF_PHASE_BITS'(T_RP - 1);

   ref_state_t                r_state;
   logic [REF_PHASE_BITS-1:0] r_phase;
   logic                      r_ren_n;
   logic                      r_ras_n;
   logic                      r_busy;
   logic                      r_grant;

   ref_state_t                w_state_nxt;
   logic [REF_PHASE_BITS-1:0] w_phase_nxt;
   logic                      w_row_inc;
   logic                      w_ren_n_nxt;

   // Next state, phase and row advance.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_row_inc   = 1'b0;
      w_ren_n_nxt = 1'b1;

      case (r_state)
         IDLE: begin
            // Refresh wins over a simultaneous CPU request.
            if (!rreq_n) begin
               w_state_nxt = RAS;
            end else if (cpu_req) begin
               w_state_nxt = CPU;
            end
         end
         CPU: begin
            // A granted CPU cycle is never preempted; refresh follows directly.
            if (cpu_done) begin
               w_state_nxt = rreq_n ? IDLE : RAS;
            end
         end
         RAS: begin
            if (r_phase == PH_RAS_LAST) begin
               w_state_nxt = PRE;
               w_phase_nxt = '0;
            end else begin
               w_phase_nxt = r_phase + REF_PHASE_BITS'(1);
            end
         end
         PRE: begin
            if (r_phase == PH_RP_LAST) begin
               w_state_nxt = IDLE;
               w_phase_nxt = '0;
               w_row_inc   = 1'b1;
            end else begin
               w_phase_nxt = r_phase + REF_PHASE_BITS'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_phase_nxt = '0;
         end
      endcase

      // Strobe only on entry into RAS, so a still-low rreq_n mid-refresh is ignored.
      if ((r_state == IDLE || r_state == CPU) && w_state_nxt == RAS) begin
         w_ren_n_nxt = 1'b0;
      end
   end

   // State register; outputs are registered from the next state so they
   // change on the same edge that takes the decision.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_phase <= '0;
         r_ren_n <= 1'b1;
         r_ras_n <= 1'b1;
         r_busy  <= 1'b0;
         r_grant <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_ren_n <= w_ren_n_nxt;
         r_ras_n <= (w_state_nxt != RAS);
         r_busy  <= (w_state_nxt == RAS) || (w_state_nxt == PRE);
         r_grant <= (w_state_nxt == CPU);
      end
   end

   refresh_row_ctr #(
      .W (ROW_BITS)
   ) u_row_ctr (
      .i_clk   (CLK),
      .i_clr   (RESET),
      .i_inc   (w_row_inc),
      .o_count (ref_addr)
   );

   assign ren_n     = r_ren_n;
   assign ref_ras_n = r_ras_n;
   assign ref_busy  = r_busy;
   assign cpu_grant = r_grant;

endmodule

// File: tb/tb_dram_refresh_ctl.sv
// Self-checking bench for dram_refresh_ctl: a cycle model predicts all
// outputs each edge into a scoreboard queue, plus directed checks on
// strobe widths, arbitration ordering and row wrap.
module tb_dram_refresh_ctl;

   localparam int ROW_BITS = 8;
   localparam int T_RAS    = 3;
   localparam int T_RP     = 2;

   localparam int M_IDLE = 0;
   localparam int M_CPU  = 1;
   localparam int M_RAS  = 2;
   localparam int M_PRE  = 3;

   logic                CLK = 1'b0;
   logic                RESET, rreq_n, cpu_req, cpu_done;
   logic                ren_n, cpu_grant, ref_ras_n, ref_busy;
   logic [ROW_BITS-1:0] ref_addr;

   dram_refresh_ctl #(
      .ROW_BITS (ROW_BITS),
      .T_RAS    (T_RAS),
      .T_RP     (T_RP)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .rreq_n    (rreq_n),
      .ren_n     (ren_n),
      .cpu_req   (cpu_req),
      .cpu_done  (cpu_done),
      .cpu_grant (cpu_grant),
      .ref_ras_n (ref_ras_n),
      .ref_addr  (ref_addr),
      .ref_busy  (ref_busy)
   );

   initial forever #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   int                  m_mode = M_IDLE;
   int                  m_left = 0;
   logic [ROW_BITS-1:0] m_addr = '0;
   bit                  m_strobe = 1'b0;

   logic [11:0] exp_q[$];
   string       cur_tag = "init";

   // Timer controller emulation and directed-check bookkeeping
   bit auto_tmr = 1'b1;
   bit clr_pend = 1'b0;
   int cyc = 0;
   int n_ren = 0, n_ras = 0, n_busy = 0;
   int t_busy_fall = -1, t_grant_rise = -1;
   bit prev_busy = 1'b0, prev_grant = 1'b0;

   task automatic start_ref();
      m_mode   = M_RAS;
      m_left   = T_RAS;
      m_strobe = 1'b1;
   endtask

   // Model what the DUT will show after the coming edge, given current inputs.
   task automatic model_edge();
      m_strobe = 1'b0;
      if (RESET) begin
         m_mode = M_IDLE;
         m_left = 0;
         m_addr = '0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (!rreq_n) start_ref();
               else if (cpu_req) m_mode = M_CPU;
            end
            M_CPU: begin
               if (cpu_done) begin
                  if (!rreq_n) start_ref();
                  else m_mode = M_IDLE;
               end
            end
            M_RAS: begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = M_PRE;
                  m_left = T_RP;
               end
            end
            default: begin
               m_left--;
               if (m_left == 0) begin
                  m_mode = M_IDLE;
                  m_addr = m_addr + 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic step();
      logic [11:0] e;
      logic [11:0] g;
      model_edge();
      exp_q.push_back({~m_strobe, (m_mode != M_RAS),
                       (m_mode == M_RAS || m_mode == M_PRE), (m_mode == M_CPU), m_addr});
      @(posedge CLK);
      #1;
      cyc++;
      e = exp_q.pop_front();
      g = {ren_n, ref_ras_n, ref_busy, cpu_grant, ref_addr};
      chk(cur_tag, 32'(g), 32'(e));
      if (!ren_n) n_ren++;
      if (!ref_ras_n) n_ras++;
      if (ref_busy) n_busy++;
      if (prev_busy && !ref_busy) t_busy_fall = cyc;
      if (!prev_grant && cpu_grant) t_grant_rise = cyc;
      prev_busy  = ref_busy;
      prev_grant = cpu_grant;
      // Timer samples ren_n=0 at the next edge and clears its request then.
      if (auto_tmr) begin
         if (clr_pend) rreq_n = 1'b1;
         clr_pend = !ren_n;
      end
   endtask

   initial begin
      RESET = 1'b1; rreq_n = 1'b1; cpu_req = 1'b0; cpu_done = 1'b0;

      cur_tag = "reset";
      step(); step();
      RESET = 1'b0;
      chk("reset_outs", 32'({ren_n, ref_ras_n, ref_busy, cpu_grant, ref_addr}), 32'h0000_0C00);

      cur_tag = "idle";
      repeat (20) step();
      chk("idle_outs", 32'({ren_n, ref_ras_n, ref_busy, cpu_grant, ref_addr}), 32'h0000_0C00);

      // Single refresh
      cur_tag = "single";
      n_ren = 0; n_ras = 0; n_busy = 0;
      rreq_n = 1'b0;
      repeat (8) step();
      chk("single_ren_cycles", 32'(n_ren), 32'd1);
      chk("single_ras_cycles", 32'(n_ras), 32'(T_RAS));
      chk("single_busy_cycles", 32'(n_busy), 32'(T_RAS + T_RP));
      chk("single_addr", 32'(ref_addr), 32'd1);

      // Collision: refresh first, grant one cycle after busy falls
      cur_tag = "collision";
      t_busy_fall = -1; t_grant_rise = -1;
      rreq_n = 1'b0; cpu_req = 1'b1;
      repeat (8) step();
      chk("collision_gap", 32'(t_grant_rise - t_busy_fall), 32'd1);
      chk("collision_grant", 32'(cpu_grant), 32'd1);
      cpu_req = 1'b0; cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
      step();

      // Deferral: pending refresh waits for cpu_done
      cur_tag = "deferral";
      cpu_req = 1'b1;
      step();
      cpu_req = 1'b0; rreq_n = 1'b0; n_ras = 0;
      repeat (4) step();
      chk("defer_no_ras", 32'(n_ras), 32'd0);
      cpu_done = 1'b1;
      step();
      cpu_done = 1'b0;
      chk("defer_start", 32'({ref_ras_n, ren_n, cpu_grant, ref_busy}), 32'h1);
      repeat (7) step();
      chk("defer_addr", 32'(ref_addr), 32'd3);

      // Wrap: 256 refreshes from a cleared counter
      cur_tag = "wrap";
      RESET = 1'b1; clr_pend = 1'b0; rreq_n = 1'b1;
      step();
      RESET = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rreq_n = 1'b0;
         repeat (T_RAS + T_RP + 1) step();
         if (i == 127 || i == 254 || i == 255)
            chk("wrap_addr", 32'(ref_addr), 32'((i + 1) % 256));
      end

      // Reset during the second RAS cycle
      cur_tag = "rst_mid";
      rreq_n = 1'b0;
      repeat (T_RAS + T_RP + 1) step();
      rreq_n = 1'b0;
      step(); step();
      RESET = 1'b1; rreq_n = 1'b1; clr_pend = 1'b0;
      step();
      RESET = 1'b0;
      chk("rst_mid_outs", 32'({ren_n, ref_ras_n, ref_busy, cpu_grant, ref_addr}), 32'h0000_0C00);
      n_ren = 0;
      repeat (6) step();
      chk("rst_mid_no_strobe", 32'(n_ren), 32'd0);

      // Request held low past the acknowledge re-triggers a refresh from IDLE
      cur_tag = "fault_rearm";
      auto_tmr = 1'b0; n_ren = 0;
      rreq_n = 1'b0;
      repeat (7) step();
      rreq_n = 1'b1;
      repeat (8) step();
      auto_tmr = 1'b1;
      chk("fault_strobes", 32'(n_ren), 32'd2);
      chk("fault_addr", 32'(ref_addr), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
